// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared constants and types for the decode/register-read stage.
//   - datapath geometry (NUM_REGS, ADDR_W, DATA_W, INSTR_W)
//   - opcode encodings and the ALU function codes used by LLB/LHB
//   - halt state type and an ALU-class opcode helper
package id_stage_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int INSTR_W  = 16;

    // ALU class occupies opcodes OPC_ALU_MIN..OPC_ALU_MAX; func is opcode[2:0]
    localparam logic [3:0] OPC_ALU_MIN = 4'b0000;
    localparam logic [3:0] OPC_ALU_MAX = 4'b0111;
    localparam logic [3:0] OPC_LLB     = 4'b1010;
    localparam logic [3:0] OPC_LHB     = 4'b1011;
    localparam logic [3:0] OPC_HLT     = 4'b1111;

    // EX function codes that implement the byte-load operations
    localparam logic [2:0] LLB_FUNC = 3'b110;
    localparam logic [2:0] LHB_FUNC = 3'b111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    function automatic logic is_alu(input logic [3:0] opc);
        return (opc >= OPC_ALU_MIN) && (opc <= OPC_ALU_MAX);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: instruction/operand bundle between the fetch side, the
// decode stage and EX.
//   master: drives instr, wb_data, zr; observes decode outputs
//   slave : the id_stage itself
interface id_stage_if;
    import id_stage_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  wb_data;
    logic               zr;
    logic [DATA_W-1:0]  src0;
    logic [DATA_W-1:0]  p1;
    logic [7:0]         imm8;
    logic [3:0]         shamt;
    logic [2:0]         func;
    logic               src1sel;
    logic               rf_we;
    logic               zflag;
    logic               hlt;

    modport master (
        output instr, wb_data, zr,
        input  src0, p1, imm8, shamt, func, src1sel, rf_we, zflag, hlt
    );

    modport slave (
        input  instr, wb_data, zr,
        output src0, p1, imm8, shamt, func, src1sel, rf_we, zflag, hlt
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// id_stage_reg_file: NUM_REGS x DATA_W register file.
//   clk, rst      : clock, async active-high reset (clears every entry)
//   ra0/rd0       : combinational read port 0
//   ra1/rd1       : combinational read port 1
//   we, wa, wd    : synchronous write port
// R0 is hardwired to zero: writes to it are dropped and reads return 0.
// Reads show the current contents, so a same-cycle write is not bypassed.
module id_stage_reg_file
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd0 = (ra0 == '0) ? '0 : mem[ra0];
    assign rd1 = (ra1 == '0) ? '0 : mem[ra1];

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode and register read, feeding EX in the same
// cycle the instruction is presented.
//   clk, rst : clock, async active-high reset
//   bus      : id_stage_if.slave -- instr/wb_data/zr in, decoded operand
//              and control fields, rf_we, zflag, hlt out
// Owns the register file, the zero flag and the halt state.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_RUN    | normal execution; writes and flag updates allowed
//   ST_HALTED | HLT seen; writes and flag frozen until rst, decode live
module id_stage
    import id_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;

    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic [2:0]        func_dec;
    logic              src1sel_dec;
    logic              we_dec;
    logic              flag_upd;

    halt_state_t       state;
    halt_state_t       state_nxt;
    logic              halted;
    logic              rf_we_int;
    logic              zflag_q;

    assign opcode = bus.instr[15:12];
    assign rd     = bus.instr[11:8];
    assign rs     = bus.instr[7:4];
    assign rt     = bus.instr[3:0];

    always_comb begin
        func_dec    = 3'b000;
        src1sel_dec = 1'b0;
        we_dec      = 1'b0;
        flag_upd    = 1'b0;
        ra0         = rs;
        ra1         = rt;
        if (is_alu(opcode)) begin
            func_dec = opcode[2:0];
            we_dec   = 1'b1;
            flag_upd = 1'b1;
        end else if (opcode == OPC_LLB || opcode == OPC_LHB) begin
            // byte loads merge imm8 into the old rd value, so rd is read on both ports
            func_dec    = (opcode == OPC_LLB) ? LLB_FUNC : LHB_FUNC;
            src1sel_dec = 1'b1;
            we_dec      = 1'b1;
            ra0         = rd;
            ra1         = rd;
        end
    end

    assign rf_we_int = we_dec && !halted;

    id_stage_reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra0 (ra0),
        .ra1 (ra1),
        .rd0 (rdata0),
        .rd1 (rdata1),
        .we  (rf_we_int),
        .wa  (rd),
        .wd  (bus.wb_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zflag_q <= 1'b0;
        end else if (flag_upd && !halted) begin
            zflag_q <= bus.zr;
        end
    end

    // halt FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // halt FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (opcode == OPC_HLT) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // halt FSM: outputs
    always_comb begin
        halted = (state == ST_HALTED);
    end

    assign bus.src0    = rdata0;
    assign bus.p1      = rdata1;
    assign bus.imm8    = bus.instr[7:0];
    assign bus.shamt   = bus.instr[3:0];
    assign bus.func    = func_dec;
    assign bus.src1sel = src1sel_dec;
    assign bus.rf_we   = rf_we_int;
    assign bus.zflag   = zflag_q;
    assign bus.hlt     = halted;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
// Inputs change on the falling edge; outputs are sampled 1 ns later
// (combinational) or 1 ns after the rising edge (registered).
module tb_id_stage;
    import id_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] i, input logic [15:0] w, input logic z);
        @(negedge clk);
        bus.instr   = i;
        bus.wb_data = w;
        bus.zr      = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.instr   = 16'hC000;
        bus.wb_data = 16'h0000;
        bus.zr      = 1'b0;
        #12;
        n_cmp++;
        if (bus.zflag !== 1'b0 || bus.hlt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: zflag=%b hlt=%b, want 0 0", bus.zflag, bus.hlt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive({8'h00, i[3:0], i[3:0]}, 16'h0000, 1'b0);
            n_cmp++;
            if (bus.src0 !== 16'h0000 || bus.p1 !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_reg%0d: src0=%h p1=%h, want 0000 0000", i, bus.src0, bus.p1);
            end
        end
    endtask

    task automatic test_decode();
        logic [15:0] vi [6];
        logic [2:0]  vf [6];
        logic        vs [6];
        logic        vw [6];
        vi = '{16'h3000, 16'h7000, 16'h8000, 16'h9000, 16'hC000, 16'hE000};
        vf = '{3'd3,     3'd7,     3'd0,     3'd0,     3'd0,     3'd0};
        vs = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0};
        vw = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(vi[k] | 16'h00A7, 16'h0000, 1'b0);
            n_cmp++;
            if (bus.func !== vf[k] || bus.src1sel !== vs[k] || bus.rf_we !== vw[k] ||
                bus.imm8 !== 8'hA7 || bus.shamt !== 4'h7) begin
                n_err++;
                $display("FAIL decode_%h: func=%0d sel=%b we=%b imm8=%h shamt=%h, want %0d %b %b a7 7",
                         vi[k], bus.func, bus.src1sel, bus.rf_we, bus.imm8, bus.shamt, vf[k], vs[k], vw[k]);
            end
        end
    endtask

    task automatic test_write_no_bypass();
        drive(16'h0333, 16'h1234, 1'b0);
        n_cmp++;
        if (bus.src0 !== 16'h0000 || bus.rf_we !== 1'b1) begin
            n_err++;
            $display("FAIL no_bypass: src0=%h we=%b, want 0000 1", bus.src0, bus.rf_we);
        end
        tick();
        n_cmp++;
        if (bus.src0 !== 16'h1234 || bus.p1 !== 16'h1234) begin
            n_err++;
            $display("FAIL write_r3: src0=%h p1=%h, want 1234 1234", bus.src0, bus.p1);
        end
    endtask

    task automatic test_r0();
        drive(16'h0000, 16'hFFFF, 1'b1);
        tick();
        n_cmp++;
        if (bus.src0 !== 16'h0000 || bus.zflag !== 1'b1) begin
            n_err++;
            $display("FAIL r0_write: src0=%h zflag=%b, want 0000 1", bus.src0, bus.zflag);
        end
        drive(16'h0000, 16'hFFFF, 1'b0);
        tick();
        n_cmp++;
        if (bus.zflag !== 1'b0) begin
            n_err++;
            $display("FAIL r0_flag_clear: zflag=%b, want 0", bus.zflag);
        end
    endtask

    task automatic test_llb_lhb();
        drive(16'h0500, 16'hABCD, 1'b0);
        tick();
        drive(16'hA53C, 16'hABCD, 1'b1);
        n_cmp++;
        if (bus.src0 !== 16'hABCD || bus.p1 !== 16'hABCD || bus.src1sel !== 1'b1 ||
            bus.imm8 !== 8'h3C || bus.func !== LLB_FUNC || bus.rf_we !== 1'b1) begin
            n_err++;
            $display("FAIL llb_decode: src0=%h p1=%h sel=%b imm8=%h func=%0d we=%b, want abcd abcd 1 3c %0d 1",
                     bus.src0, bus.p1, bus.src1sel, bus.imm8, bus.func, bus.rf_we, LLB_FUNC);
        end
        tick();
        n_cmp++;
        if (bus.zflag !== 1'b0) begin
            n_err++;
            $display("FAIL llb_flag_hold: zflag=%b, want 0", bus.zflag);
        end
        drive(16'hB512, 16'hABCD, 1'b1);
        n_cmp++;
        if (bus.func !== LHB_FUNC || bus.src1sel !== 1'b1 || bus.src0 !== 16'hABCD) begin
            n_err++;
            $display("FAIL lhb_decode: func=%0d sel=%b src0=%h, want %0d 1 abcd",
                     bus.func, bus.src1sel, bus.src0, LHB_FUNC);
        end
        tick();
    endtask

    task automatic test_halt();
        drive(16'h0700, 16'h0042, 1'b1);
        tick();
        drive(16'hF000, 16'h9999, 1'b0);
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.hlt !== 1'b0) begin
            n_err++;
            $display("FAIL hlt_pre: we=%b hlt=%b, want 0 0", bus.rf_we, bus.hlt);
        end
        tick();
        n_cmp++;
        if (bus.hlt !== 1'b1) begin
            n_err++;
            $display("FAIL hlt_set: hlt=%b, want 1", bus.hlt);
        end
        drive(16'h1777, 16'h5555, 1'b0);
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.func !== 3'd1 || bus.src0 !== 16'h0042) begin
            n_err++;
            $display("FAIL halted_decode: we=%b func=%0d src0=%h, want 0 1 0042", bus.rf_we, bus.func, bus.src0);
        end
        tick();
        n_cmp++;
        if (bus.src0 !== 16'h0042 || bus.zflag !== 1'b1 || bus.hlt !== 1'b1) begin
            n_err++;
            $display("FAIL halted_frozen: src0=%h zflag=%b hlt=%b, want 0042 1 1", bus.src0, bus.zflag, bus.hlt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.hlt !== 1'b0 || bus.src0 !== 16'h0000 || bus.zflag !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: hlt=%b src0=%h zflag=%b, want 0 0000 0", bus.hlt, bus.src0, bus.zflag);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0977, 16'h00EE, 1'b0);
        tick();
        drive(16'h0099, 16'h0000, 1'b0);
        n_cmp++;
        if (bus.src0 !== 16'h00EE || bus.hlt !== 1'b0) begin
            n_err++;
            $display("FAIL run_after_reset: src0=%h hlt=%b, want 00ee 0", bus.src0, bus.hlt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_decode();
        test_write_no_bypass();
        test_r0();
        test_llb_lhb();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
